// File: rtl/sram_like_arbiter.sv
// Two-to-one sram-like arbiter: inst and data requesters share one memory port, one transaction at a time.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin tie-break via last_gnt; default is fixed data-over-inst priority.
module sram_like_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,

  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,

  output logic              gnt_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_e;

  state_e state_q, state_d;
  logic   gnt_data_q, gnt_data_d;
  logic   win_data;
  logic   gnt_req;
  logic   unused_inst_wr;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_gnt_q, last_gnt_d;  // 1 = data was granted last

  always_comb begin
    if (data_req && inst_req) begin
      win_data = ~last_gnt_q;
    end else begin
      win_data = data_req;
    end
  end
`else
  always_comb begin
    win_data = data_req;
  end
`endif

  // Instruction port is read-only towards memory.
  assign unused_inst_wr = inst_wr;

  assign gnt_req    = gnt_data_q ? data_req : inst_req;
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;
  assign gnt_data   = gnt_data_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    gnt_data_d   = gnt_data_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_gnt_d   = last_gnt_q;
`endif
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (data_req || inst_req) begin
          gnt_data_d = win_data;
          state_d    = ADDR;
`ifdef ARB_ROUND_ROBIN_EN
          last_gnt_d = win_data;
`endif
        end
      end

      ADDR: begin
        if (gnt_data_q) begin
          mem_wr    = data_wr;
          mem_size  = data_size;
          mem_addr  = data_addr;
          mem_wdata = data_wdata;
        end else begin
          mem_size  = inst_size;
          mem_addr  = inst_addr;
        end
        // A withdrawn request drops mem_req at once and abandons the grant.
        if (!gnt_req) begin
          state_d = IDLE;
        end else begin
          mem_req = 1'b1;
          if (mem_addr_ok) begin
            inst_addr_ok = ~gnt_data_q;
            data_addr_ok = gnt_data_q;
            state_d      = DATA;
          end
        end
      end

      DATA: begin
        if (mem_data_ok) begin
          inst_data_ok = ~gnt_data_q;
          data_data_ok = gnt_data_q;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      gnt_data_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      gnt_data_q <= gnt_data_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt_q <= last_gnt_d;
`endif
    end
  end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Two-to-one arbiter that shares a single sram-like memory port between the CPU instruction-fetch port and the data-access port. It serialises transactions with one outstanding request at a time and routes `addr_ok`, `data_ok` and `rdata` back to the granted requester. The two requester ports connect to the datapath's `inst_*` and `data_*` sram-like ports. The memory port connects to the sram-to-AXI bridge.

## Interface
Parameters:
- `ADDR_W`, 32, address width of all three ports.
- `DATA_W`, 32, data width of all three ports.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `inst_req` in 1, `inst_wr` in 1, `inst_size` in 2, `inst_addr` in ADDR_W: instruction request fields.
- `inst_rdata` out DATA_W, `inst_addr_ok` out 1, `inst_data_ok` out 1: instruction responses.
- `data_req` in 1, `data_wr` in 1, `data_size` in 2, `data_addr` in ADDR_W, `data_wdata` in DATA_W: data request fields.
- `data_rdata` out DATA_W, `data_addr_ok` out 1, `data_data_ok` out 1: data responses.
- `mem_req` out 1, `mem_wr` out 1, `mem_size` out 2, `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: shared memory request.
- `mem_rdata` in DATA_W, `mem_addr_ok` in 1, `mem_data_ok` in 1: shared memory response.
- `gnt_data`  out  1  registered. 1 = data port owns the memory port.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ADDR, DATA. Registers: `state`, `gnt_data`, and `last_gnt` (last_gnt exists only with the macro).
- IDLE:
  - If `data_req` or `inst_req` is high, select the winner, register it into `gnt_data`, and go to ADDR.
  - If neither request is high, stay in IDLE.
- Arbitration without the macro: fixed priority, data port over instruction port.
- ADDR:
  - Drive `mem_req`=1. `mem_wr`, `mem_size`, `mem_addr` and `mem_wdata` are muxed from the granted port. Instruction grant forces `mem_wr`=0 and `mem_wdata`=0.
  - On `mem_addr_ok`=1: pulse the granted port's `*_addr_ok` in the same cycle (combinational) and go to DATA.
  - If the granted port's `*_req` drops before `mem_addr_ok`: `mem_req` falls in the same cycle, go to IDLE, and issue no transaction.
  - `mem_data_ok` in ADDR is a protocol violation and is ignored.
- DATA:
  - `mem_req`=0.
  - On `mem_data_ok`=1: pulse the granted port's `*_data_ok` combinationally and go to IDLE.
  - The other port's `*_req` is held off and its `*_addr_ok` and `*_data_ok` stay 0.
- `inst_rdata` and `data_rdata` both equal `mem_rdata` at all times. Only the `*_data_ok` strobe qualifies them.
- The non-granted port sees `addr_ok`=0 and `data_ok`=0 in every cycle.
- Only one transaction is outstanding at any time. No request is queued inside the block. Requesters hold `*_req` and their request fields stable until their own `*_addr_ok`.

## Timing
- Reset values: `state`=IDLE, `gnt_data`=0, `busy`=0, `mem_req`=0, `mem_wr`=0, `mem_size`=0, `mem_addr`=0, `mem_wdata`=0, all `*_addr_ok` and `*_data_ok` = 0.
- Asserting `rstn` mid-transaction returns the FSM to IDLE immediately and drops `mem_req`. Any in-flight `mem_data_ok` arriving after reset release is ignored because the FSM is in IDLE.
- Request latency: a `*_req` rising in cycle N gives `mem_req`=1 in cycle N+1.
- Minimum transaction: N+1 ADDR, N+2 DATA with `data_ok`, N+3 IDLE. Next grant goes to ADDR at N+4.
- Throughput: one transaction per 3 cycles minimum.
- IDLE always costs one bubble cycle between transactions.
- `*_addr_ok` and `*_data_ok` to requesters are pure combinational pass-through. There are no extra cycles of latency.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: on simultaneous requests in IDLE, grant the port not recorded in `last_gnt`. `last_gnt` updates on each IDLE→ADDR grant and resets to "data", so the instruction port wins the first tie. A single requester is always granted.
- Not defined: fixed data-over-instruction priority, and no `last_gnt` register.

## Test plan
- Instruction-only read: `inst_req`=1 with `inst_addr`=0xBFC0_0000; memory gives `addr_ok` one cycle after `mem_req` and `data_ok` with 0x2408_0001 one cycle later. Required: `mem_addr`=0xBFC0_0000, `mem_wr`=0, `inst_data_ok` pulses once with `inst_rdata`=0x2408_0001, `data_*_ok` stay 0.
- Simultaneous requests, macro off: data store to 0x8000_0010 with 0xDEAD_BEEF and an instruction fetch in the same cycle. Required: the store is issued first with `gnt_data`=1; the fetch is issued after the store's `data_ok` plus one IDLE cycle.
- Simultaneous requests, macro on: both ports request continuously for 4 transactions. Required: grant order inst, data, inst, data.
- Memory backpressure: `mem_addr_ok` held low for 5 cycles. Required: `mem_req` and its fields stay stable for those 5 cycles, and no requester `addr_ok` pulses until `mem_addr_ok` rises.
- Reset in DATA: pull `rstn` low while waiting for `mem_data_ok`. Required: `mem_req`=0 and `busy`=0 immediately; a later stray `mem_data_ok` produces no `*_data_ok`.
- Request withdrawal: `data_req` drops in ADDR before `mem_addr_ok`. Required: `mem_req` falls in the same cycle, FSM returns to IDLE, and no `data_addr_ok` or `data_data_ok` is produced.
